// File: rtl/hub75_scan_reader.sv
// HUB75 scan engine: reads RGB pixels from a 1-cycle-latency frame source and
// shifts BCM bit planes (LSB first) out to the panel with SCLK/LAT/OE/row.
module hub75_scan_reader #(
  parameter int hpixel_p    = 8,
  parameter int vpixel_p    = 8,
  parameter int bpp_p       = 8,
  parameter int segments_p  = 2,
  parameter int disp_base_p = 1,
  localparam int rows_p       = vpixel_p / segments_p,
  localparam int addr_width_p = $clog2(hpixel_p * vpixel_p)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_enable,
  output logic                           o_busy,
  output logic                           o_frame_done,
  output logic [addr_width_p-1:0]        o_rd_addr,
  input  logic [segments_p*3*bpp_p-1:0]  i_rd_data,
  output logic [segments_p*3-1:0]        o_rgb,
  output logic                           o_sclk,
  output logic                           o_lat,
  output logic                           o_oe,
  output logic [$clog2(rows_p)-1:0]      o_row
);

  localparam int col_w    = (hpixel_p > 1) ? $clog2(hpixel_p) : 1;
  localparam int plane_w  = (bpp_p > 1) ? $clog2(bpp_p) : 1;
  localparam int row_w    = $clog2(rows_p);
  localparam int disp_max = disp_base_p << (bpp_p - 1);
  localparam int disp_w   = (disp_max > 1) ? $clog2(disp_max + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    PREFETCH,
    SHIFT,
    LATCH,
    DISPLAY
  } state_e;

  state_e              state_q, state_d;
  logic [plane_w-1:0]  plane_q, plane_d;
  logic [row_w-1:0]    row_q, row_d;
  logic [col_w-1:0]    col_q, col_d;
  logic                phase_q, phase_d;
  logic [disp_w-1:0]   disp_q, disp_d;

  logic [segments_p-1:0][2:0][bpp_p-1:0] rd_view;
  logic [segments_p*3-1:0]               plane_bits;
  logic [addr_width_p-1:0]               row_base;
  logic [col_w-1:0]                      col_sel;

  assign rd_view  = i_rd_data;
  assign row_base = addr_width_p'(row_q * hpixel_p);

  for (genvar s = 0; s < segments_p; s++) begin : g_seg
    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
      assign plane_bits[s*3+ch] = rd_view[s][ch][plane_q];
    end
  end

  // Phase 0 holds column c's address so the source data stays valid through
  // phase 1; phase 1 already requests c+1 (never past the last column).
  always_comb begin
    col_sel = col_q;
    if (phase_q && (col_q != col_w'(hpixel_p - 1))) col_sel = col_q + 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    plane_d      = plane_q;
    row_d        = row_q;
    col_d        = col_q;
    phase_d      = phase_q;
    disp_d       = disp_q;
    o_busy       = (state_q != IDLE);
    o_frame_done = 1'b0;
    o_rd_addr    = '0;
    o_rgb        = '0;
    o_sclk       = 1'b0;
    o_lat        = 1'b0;
    o_oe         = 1'b1;
    o_row        = row_q;

    case (state_q)
      IDLE: begin
        if (i_enable) begin
          state_d = PREFETCH;
          plane_d = '0;
          row_d   = '0;
        end
      end
      PREFETCH: begin
        o_rd_addr = row_base;
        col_d     = '0;
        phase_d   = 1'b0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        o_sclk    = phase_q;
        o_rgb     = plane_bits;
        o_rd_addr = row_base + addr_width_p'(col_sel);
        phase_d   = ~phase_q;
        if (phase_q) begin
          if (col_q == col_w'(hpixel_p - 1)) state_d = LATCH;
          else                              col_d   = col_q + 1'b1;
        end
      end
      LATCH: begin
        o_lat   = 1'b1;
        disp_d  = disp_w'((disp_base_p << plane_q) - 1);
        state_d = DISPLAY;
      end
      DISPLAY: begin
        o_oe = 1'b0;
        if (disp_q == '0) begin
          state_d = PREFETCH;
          if (row_q == row_w'(rows_p - 1)) begin
            row_d = '0;
            if (plane_q == plane_w'(bpp_p - 1)) begin
              plane_d      = '0;
              o_frame_done = 1'b1;
              if (!i_enable) state_d = IDLE;
            end else begin
              plane_d = plane_q + 1'b1;
            end
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          disp_d = disp_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      plane_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      phase_q <= 1'b0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      plane_q <= plane_d;
      row_q   <= row_d;
      col_q   <= col_d;
      phase_q <= phase_d;
      disp_q  <= disp_d;
    end
  end

endmodule

// File: tb/tb_hub75_scan_reader.sv
// Scoreboard bench for hub75_scan_reader: a ROM source model, a frame-level
// reference model feeding expectation queues, and a negedge monitor.
module tb_hub75_scan_reader;

  logic        clk;
  logic        rst;
  logic        i_enable;
  logic        o_busy;
  logic        o_frame_done;
  logic [5:0]  o_rd_addr;
  logic [47:0] i_rd_data;
  logic [5:0]  o_rgb;
  logic        o_sclk;
  logic        o_lat;
  logic        o_oe;
  logic [1:0]  o_row;

  hub75_scan_reader #(
    .hpixel_p   (8),
    .vpixel_p   (8),
    .bpp_p      (8),
    .segments_p (2),
    .disp_base_p(1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_enable    (i_enable),
    .o_busy      (o_busy),
    .o_frame_done(o_frame_done),
    .o_rd_addr   (o_rd_addr),
    .i_rd_data   (i_rd_data),
    .o_rgb       (o_rgb),
    .o_sclk      (o_sclk),
    .o_lat       (o_lat),
    .o_oe        (o_oe),
    .o_row       (o_row)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 8x8 colour ROM {R,G,B}; segment 1 lives 32 words above segment 0.
  logic [23:0] rom [64];
  always_ff @(posedge clk)
    i_rd_data <= {rom[{1'b1, o_rd_addr[4:0]}], rom[{1'b0, o_rd_addr[4:0]}]};

  typedef struct packed {
    logic [5:0] rgb;
    logic [5:0] addr;
  } sclk_t;

  sclk_t      q_sclk [$];
  logic [1:0] q_lat  [$];
  int         q_disp [$];
  int         q_fd   [$];

  int n_chk  = 0;
  int n_fail = 0;
  int lat_cnt = 0;
  int sclk_cnt = 0;
  int fd_cnt = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_empty(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event seen but no expectation queued", name);
  endtask

  function automatic logic [5:0] exp_rgb(input int p, input int r, input int c);
    logic [5:0]  a;
    logic [23:0] w0, w1;
    a  = 6'(r * 8 + c);
    w0 = rom[a];
    w1 = rom[a + 6'd32];
    return {1'(w1 >> (16 + p)), 1'(w1 >> (8 + p)), 1'(w1 >> p),
            1'(w0 >> (16 + p)), 1'(w0 >> (8 + p)), 1'(w0 >> p)};
  endfunction

  // One frame: per plane, per row, 8 pixel shifts, a latch, then 1<<plane OE-low.
  task automatic push_frame(input int period);
    for (int p = 0; p < 8; p++)
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 8; c++) q_sclk.push_back({exp_rgb(p, r, c), 6'(r * 8 + c)});
        q_lat.push_back(2'(r));
        q_disp.push_back(1 << p);
      end
    q_fd.push_back(period);
  endtask

  task automatic flush_queues();
    q_sclk.delete();
    q_lat.delete();
    q_disp.delete();
    q_fd.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_oe"},    o_oe, 1);
    check({tag, "_lat"},   o_lat, 0);
    check({tag, "_sclk"},  o_sclk, 0);
    check({tag, "_rgb"},   o_rgb, 0);
    check({tag, "_addr"},  o_rd_addr, 0);
    check({tag, "_row"},   o_row, 0);
    check({tag, "_busy"},  o_busy, 0);
    check({tag, "_fdone"}, o_frame_done, 0);
  endtask

  task automatic check_queues_empty(input string tag);
    check({tag, "_sclk_left"}, q_sclk.size(), 0);
    check({tag, "_lat_left"},  q_lat.size(), 0);
    check({tag, "_disp_left"}, q_disp.size(), 0);
    check({tag, "_fd_left"},   q_fd.size(), 0);
  endtask

  // Monitor
  initial begin
    logic       prev_sclk, prev_oe;
    logic [5:0] prev_addr;
    int         run, cyc, last_fd;
    sclk_t      es;
    prev_sclk = 1'b0;
    prev_oe   = 1'b1;
    prev_addr = '0;
    run       = 0;
    cyc       = 0;
    last_fd   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_sclk = 1'b0;
        prev_oe   = 1'b1;
        run       = 0;
        sclk_cnt  = 0;
      end else begin
        cyc++;
        check("addr_range", (o_rd_addr < 6'd32) ? 1 : 0, 1);
        if (o_sclk && !prev_sclk) begin
          if (q_sclk.size() == 0) fail_empty("sclk");
          else begin
            es = q_sclk.pop_front();
            check("rgb_at_sclk", o_rgb, es.rgb);
            check("rd_addr_seq", prev_addr, es.addr);
            check("oe_during_shift", o_oe, 1);
          end
          sclk_cnt++;
        end
        if (o_lat) begin
          if (q_lat.size() == 0) fail_empty("lat");
          else check("lat_row", o_row, q_lat.pop_front());
          check("sclk_per_lat", sclk_cnt, 8);
          check("oe_during_lat", o_oe, 1);
          sclk_cnt = 0;
          lat_cnt++;
        end
        if (!o_oe) run++;
        else if (!prev_oe) begin
          if (q_disp.size() == 0) fail_empty("oe_run");
          else check("oe_run_len", run, q_disp.pop_front());
          run = 0;
        end
        if (o_frame_done) begin
          if (q_fd.size() == 0) fail_empty("frame_done");
          else begin
            int ep;
            ep = q_fd.pop_front();
            if (ep != 0) check("frame_period", cyc - last_fd, ep);
          end
          last_fd = cyc;
          fd_cnt++;
        end
        prev_sclk = o_sclk;
        prev_oe   = o_oe;
        prev_addr = o_rd_addr;
      end
    end
  end

  // Stimulus
  initial begin
    int base;
    rst      = 1'b1;
    i_enable = 1'b0;
    for (int i = 0; i < 64; i++) rom[6'(i)] = 24'($urandom);
    rom[0] = 24'h810080;

    repeat (3) tick();
    check_reset("rst");
    rst = 1'b0;
    repeat (5) tick();
    check_reset("idle");

    // Three back-to-back frames; enable drops during plane 3 of the third.
    push_frame(0);
    push_frame(1596);
    push_frame(1596);
    i_enable = 1'b1;
    for (int k = 0; k < 5000 && fd_cnt < 2; k++) tick();
    check("two_frames_done", fd_cnt, 2);
    repeat (300) tick();
    i_enable = 1'b0;
    for (int k = 0; k < 3000 && fd_cnt < 3; k++) tick();
    check("third_frame_done", fd_cnt, 3);
    repeat (20) tick();
    check("drop_busy", o_busy, 0);
    check("drop_oe", o_oe, 1);
    check("drop_single_fd", fd_cnt, 3);
    check_queues_empty("drop");

    // Reset during plane 2, row 1, column 5 of a new frame.
    push_frame(0);
    base = lat_cnt;
    i_enable = 1'b1;
    for (int k = 0; k < 2000 && !(lat_cnt == base + 9 && sclk_cnt == 5); k++) tick();
    check("midshift_reached", (lat_cnt == base + 9 && sclk_cnt == 5) ? 1 : 0, 1);
    rst = 1'b1;
    i_enable = 1'b0;
    flush_queues();
    tick();
    check_reset("midrst");

    push_frame(0);
    rst = 1'b0;
    i_enable = 1'b1;
    tick();
    i_enable = 1'b0;
    check("restart_busy", o_busy, 1);
    check("restart_addr", o_rd_addr, 0);
    check("restart_row", o_row, 0);
    base = fd_cnt;
    for (int k = 0; k < 3000 && fd_cnt == base; k++) tick();
    check("restart_frame_done", fd_cnt, base + 1);
    repeat (10) tick();
    check("final_busy", o_busy, 0);
    check_queues_empty("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
